// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, legal PRESCALE values, parity types.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic is_legal_prescale(input int ps);
        return (ps == PRESCALE_8) || (ps == PRESCALE_16) ||
               (ps == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver bundle: serial line and frame config in, received word and status out.
// master = line/config side, slave = the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    import uart_pkg::*;

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

endinterface

// File: rtl/uart_rx_data_sampling.sv
// Bit sampler for the UART receiver; majority-of-three voting when
// UART_RX_MAJORITY_SAMPLE_EN is defined, single mid-bit sample otherwise.
module uart_rx_data_sampling #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_in,
    output logic                  sampled_bit,
    output logic                  sample_valid
);
    import uart_pkg::*;

    logic [PRESCALE_W-1:0] half;

    assign half = prescale >> 1;

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic s0;
    logic s1;

    always_ff @(posedge CLK) begin
        if (edge_cnt == half - PRESCALE_W'(2)) s0 <= rx_in;
        if (edge_cnt == half - PRESCALE_W'(1)) s1 <= rx_in;
    end

    // third vote is the live line value, so the result lands one cycle later
    assign sample_valid = (edge_cnt == half);
    assign sampled_bit  = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
`else
    logic unused_clk;

    assign unused_clk   = CLK;
    assign sample_valid = (edge_cnt == half - PRESCALE_W'(1));
    assign sampled_bit  = rx_in;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first deserialize, parity/stop check.
// Optional majority sampling via UART_RX_MAJORITY_SAMPLE_EN.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input logic     CLK,
    input logic     RST,
    uart_rx_if.slave bus
);
    import uart_pkg::*;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                state;
    logic [PRESCALE_W-1:0] ps_q;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  stop_bit;
    logic                  smp_bit;
    logic                  smp_valid;
    logic                  bit_end;
    logic                  par_exp;

    uart_rx_data_sampling #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampling (
        .CLK          (CLK),
        .edge_cnt     (edge_cnt),
        .prescale     (ps_q),
        .rx_in        (bus.RX_IN),
        .sampled_bit  (smp_bit),
        .sample_valid (smp_valid)
    );

    assign bit_end = (edge_cnt == ps_q - PRESCALE_W'(1));
    assign par_exp = (^shift_reg) ^ (par_typ_q == PAR_ODD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            ps_q           <= '0;
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_bad        <= 1'b0;
            stop_bit       <= 1'b0;
            bus.P_DATA     <= '0;
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;
        end else begin
            bus.DATA_VALID <= 1'b0;
            if (state != ST_IDLE)
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
            case (state)
                ST_IDLE: begin
                    if (!bus.RX_IN) begin
                        state       <= ST_START;
                        edge_cnt    <= PRESCALE_W'(1);
                        bit_cnt     <= '0;
                        ps_q        <= is_legal_prescale(int'(bus.PRESCALE))
                                       ? bus.PRESCALE
                                       : PRESCALE_W'(PRESCALE_8);
                        par_en_q    <= bus.PAR_EN;
                        par_typ_q   <= bus.PAR_TYP;
                        par_bad     <= 1'b0;
                        bus.PAR_ERR <= 1'b0;
                        bus.STP_ERR <= 1'b0;
                    end
                end
                ST_START: begin
                    if (smp_valid && smp_bit) begin
                        state    <= ST_IDLE;
                        edge_cnt <= '0;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (smp_valid) shift_reg[bit_cnt] <= smp_bit;
                    if (bit_end) begin
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (smp_valid) par_bad <= (smp_bit != par_exp);
                    if (bit_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (smp_valid) stop_bit <= smp_bit;
                    if (bit_end) begin
                        state       <= ST_IDLE;
                        bus.PAR_ERR <= par_bad;
                        bus.STP_ERR <= ~stop_bit;
                        if (!par_bad && stop_bit) begin
                            bus.P_DATA     <= shift_reg;
                            bus.DATA_VALID <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: reset, parity/stop errors, false start,
// back-to-back frames, mid-frame reset, glitch rejection under UART_RX_MAJORITY_SAMPLE_EN.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_start_cyc = 0;
    int   first_start_cyc = 0;
    int   stp_rise_cyc = -1;
    logic stp_prev = 1'b0;
    int   dv_cyc_q[$];
    logic [7:0] dv_data_q[$];

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.DATA_VALID === 1'b1) begin
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(bus.P_DATA);
        end
        if (bus.STP_ERR === 1'b1 && stp_prev !== 1'b1) stp_rise_cyc = cyc;
        stp_prev = bus.STP_ERR;
    end

    task automatic hold(input logic b, input int n);
        #1 bus.RX_IN = b;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int ps,
                              input bit pen, input logic pbit,
                              input logic stop, input bit glitch);
        #1;
        last_start_cyc = cyc;
        bus.RX_IN = 1'b0;
        repeat (ps) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                hold(d[i], ps / 2 - 1);
                hold(~d[i], 1);
                hold(d[i], ps - ps / 2);
            end else begin
                hold(d[i], ps);
            end
        end
        if (pen) hold(pbit, ps);
        hold(stop, ps);
    endtask

    task automatic set_cfg(input int ps, input bit pen, input bit ptyp);
        bus.PRESCALE = 6'(ps);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        dv_cyc_q.delete();
        dv_data_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.P_DATA !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pdata got %h exp 00", bus.P_DATA);
        end
        vectors++;
        if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 000",
                     {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_parity_ok;
        set_cfg(8, 1'b1, 1'b0);
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 1) begin
            miscompares++;
            $display("FAIL t1_dv_count got %0d exp 1", dv_cyc_q.size());
        end
        vectors++;
        if (dv_cyc_q[0] - last_start_cyc !== 88) begin
            miscompares++;
            $display("FAIL t1_latency got %0d exp 88",
                     dv_cyc_q[0] - last_start_cyc);
        end
        vectors++;
        if (dv_data_q[0] !== 8'hA5 || bus.P_DATA !== 8'hA5) begin
            miscompares++;
            $display("FAIL t1_data got %h exp a5", bus.P_DATA);
        end
        vectors++;
        if ({bus.PAR_ERR, bus.STP_ERR} !== 2'b00) begin
            miscompares++;
            $display("FAIL t1_errs got %b exp 00", {bus.PAR_ERR, bus.STP_ERR});
        end
    endtask

    task automatic test_parity_error;
        set_cfg(8, 1'b1, 1'b0);
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if ({bus.PAR_ERR, bus.STP_ERR} !== 2'b10) begin
            miscompares++;
            $display("FAIL t2_errs got %b exp 10", {bus.PAR_ERR, bus.STP_ERR});
        end
        vectors++;
        if (dv_cyc_q.size() !== 0 || bus.P_DATA !== 8'hA5) begin
            miscompares++;
            $display("FAIL t2_nostrobe got %0d/%h exp 0/a5",
                     dv_cyc_q.size(), bus.P_DATA);
        end
        // odd parity frame; PAR_ERR must clear right after its start edge
        set_cfg(8, 1'b1, 1'b1);
        fork
            send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b0);
            begin
                repeat (3) @(negedge clk);
                vectors++;
                if (bus.PAR_ERR !== 1'b0) begin
                    miscompares++;
                    $display("FAIL t2_par_clear got %b exp 0", bus.PAR_ERR);
                end
            end
        join
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 1 || dv_data_q[0] !== 8'h3C) begin
            miscompares++;
            $display("FAIL t2_odd_data got %0d/%h exp 1/3c",
                     dv_cyc_q.size(), bus.P_DATA);
        end
    endtask

    task automatic test_stop_error;
        set_cfg(16, 1'b0, 1'b0);
        stp_rise_cyc = -1;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (bus.STP_ERR !== 1'b1 || stp_rise_cyc - last_start_cyc !== 160) begin
            miscompares++;
            $display("FAIL t3_stp got %b at %0d exp 1 at 160",
                     bus.STP_ERR, stp_rise_cyc - last_start_cyc);
        end
        vectors++;
        if (dv_cyc_q.size() !== 0 || bus.P_DATA !== 8'h3C) begin
            miscompares++;
            $display("FAIL t3_nostrobe got %0d/%h exp 0/3c",
                     dv_cyc_q.size(), bus.P_DATA);
        end
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (bus.STP_ERR !== 1'b0 || dv_cyc_q.size() !== 1 ||
            dv_data_q[0] !== 8'hFF) begin
            miscompares++;
            $display("FAIL t3_clean got stp=%b n=%0d d=%h exp 0/1/ff",
                     bus.STP_ERR, dv_cyc_q.size(), bus.P_DATA);
        end
    endtask

    task automatic test_false_start;
        set_cfg(8, 1'b0, 1'b0);
        hold(1'b0, 2);
        hold(1'b1, 20);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 0 || bus.P_DATA !== 8'hFF ||
            {bus.PAR_ERR, bus.STP_ERR} !== 2'b00) begin
            miscompares++;
            $display("FAIL t4_glitch got n=%0d d=%h e=%b exp 0/ff/00",
                     dv_cyc_q.size(), bus.P_DATA, {bus.PAR_ERR, bus.STP_ERR});
        end
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 1 || dv_data_q[0] !== 8'h01 ||
            dv_cyc_q[0] - last_start_cyc !== 80) begin
            miscompares++;
            $display("FAIL t4_after got n=%0d d=%h exp 1/01 lat 80",
                     dv_cyc_q.size(), bus.P_DATA);
        end
    endtask

    task automatic test_back_to_back;
        set_cfg(32, 1'b0, 1'b0);
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        first_start_cyc = last_start_cyc;
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 2) begin
            miscompares++;
            $display("FAIL t5_count got %0d exp 2", dv_cyc_q.size());
        end
        vectors++;
        if (dv_cyc_q[0] - first_start_cyc !== 320 ||
            dv_cyc_q[1] - dv_cyc_q[0] !== 320) begin
            miscompares++;
            $display("FAIL t5_spacing got %0d/%0d exp 320/320",
                     dv_cyc_q[0] - first_start_cyc, dv_cyc_q[1] - dv_cyc_q[0]);
        end
        vectors++;
        if (dv_data_q[0] !== 8'h55 || dv_data_q[1] !== 8'hAA) begin
            miscompares++;
            $display("FAIL t5_data got %h/%h exp 55/aa",
                     dv_data_q[0], dv_data_q[1]);
        end
    endtask

    task automatic test_reset_mid_frame;
        set_cfg(8, 1'b0, 1'b0);
        hold(1'b0, 8);
        hold(1'b1, 4);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.P_DATA !== 8'h00 ||
            {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== 3'b000) begin
            miscompares++;
            $display("FAIL t6_reset got %h/%b exp 00/000", bus.P_DATA,
                     {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR});
        end
        @(posedge clk);
        hold(1'b1, 100);
        vectors++;
        if (dv_cyc_q.size() !== 0) begin
            miscompares++;
            $display("FAIL t6_nostrobe got %0d exp 0", dv_cyc_q.size());
        end
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 1 || dv_data_q[0] !== 8'h81 ||
            dv_cyc_q[0] - last_start_cyc !== 80) begin
            miscompares++;
            $display("FAIL t6_after got n=%0d d=%h exp 1/81 lat 80",
                     dv_cyc_q.size(), bus.P_DATA);
        end
    endtask

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    task automatic test_majority;
        set_cfg(8, 1'b0, 1'b0);
        @(posedge clk);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 4);
        @(negedge clk);
        vectors++;
        if (dv_cyc_q.size() !== 1 || dv_data_q[0] !== 8'h81) begin
            miscompares++;
            $display("FAIL t6_majority got n=%0d d=%h exp 1/81",
                     dv_cyc_q.size(), dv_data_q[0]);
        end
    endtask
`endif

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        test_reset;
        test_parity_ok;
        test_parity_error;
        test_stop_error;
        test_false_start;
        test_back_to_back;
        test_reset_mid_frame;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
        test_majority;
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
